// File: rtl/seg_display_mux.sv
// Multiplexed common-anode seven-segment driver: IN shown as hex, unsigned or signed decimal.
// Display register updates 1 cycle (hex) or WIDTH+1 cycles (decimal) after capture; no backpressure, BUSY is status only.
module seg_display_mux #(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 6,
  parameter int SCAN_DIV = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  IN,
  input  logic [1:0]        MODE,
  input  logic              BLANK,
  output logic [DIGITS-1:0] ENBAR,
  output logic [6:0]        SEG,
  output logic              BUSY
);

  // Decimal digit count of a WIDTH-bit unsigned value: ceil(WIDTH * log10(2)).
  function automatic int dec_digits(input int w);
    longint n;
    n = (longint'(w) * 1000000 + 3321927) / 3321928;
    return int'(n);
  endfunction

  localparam int NDEC = dec_digits(WIDTH);
  localparam int NHEX = WIDTH / 4;
  localparam int BW   = 4 * DIGITS;
  localparam int CW   = $clog2(WIDTH);
  localparam int DW   = $clog2(SCAN_DIV);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

  function automatic logic [6:0] hex_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  state_t                   state_q, state_d;
  logic                     snap_vld_q, snap_vld_d;
  logic [WIDTH-1:0]         snap_in_q, snap_in_d;
  logic [1:0]               snap_mode_q, snap_mode_d;
  logic                     neg_q, neg_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [BW-1:0]            bcd_q, bcd_d;
  logic [WIDTH-1:0]         shift_q, shift_d;
  logic [DIGITS-1:0][6:0]   disp_q, disp_d;
  logic [DW-1:0]            div_q, div_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [DIGITS-1:0]        enbar_q, enbar_d;
  logic [6:0]               seg_q, seg_d;

  logic [BW-1:0]            bcd_adj;
  logic [BW-1:0]            src;
  logic                     is_hex;
  int                       rng;
  int                       msd;
  logic [DIGITS-1:0][6:0]   build;

  // Digit codes from the snapshot (hex) or finished BCD (decimal).
  always_comb begin
    is_hex = (snap_mode_q == 2'b00);
    src    = is_hex ? BW'(snap_in_q) : bcd_q;
    rng    = is_hex ? NHEX : NDEC;
    msd    = 0;
    build  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i < rng && src[4*i +: 4] != 4'd0) msd = i;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= rng || (BLANK && i > msd)) build[i] = SEG_BLANK;
      else                                build[i] = hex_seg(src[4*i +: 4]);
    end
    if (snap_mode_q == 2'b10) build[DIGITS-1] = neg_q ? SEG_MINUS : SEG_BLANK;
  end

  always_comb begin
    state_d     = state_q;
    snap_vld_d  = snap_vld_q;
    snap_in_d   = snap_in_q;
    snap_mode_d = snap_mode_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    shift_d     = shift_q;
    disp_d      = disp_q;
    bcd_adj     = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    unique case (state_q)
      IDLE: begin
        if (!snap_vld_q || IN != snap_in_q || MODE != snap_mode_q) begin
          snap_vld_d  = 1'b1;
          snap_in_d   = IN;
          snap_mode_d = MODE;
          cnt_d       = '0;
          bcd_d       = '0;
          if (MODE == 2'b00) begin
            neg_d   = 1'b0;
            state_d = LATCH;
          end else begin
            // Two's-complement negate keeps 2^(WIDTH-1) as its own unsigned magnitude.
            if (MODE == 2'b10 && IN[WIDTH-1]) begin
              shift_d = ~IN + {{(WIDTH-1){1'b0}}, 1'b1};
              neg_d   = 1'b1;
            end else begin
              shift_d = IN;
              neg_d   = 1'b0;
            end
            state_d = CONV;
          end
        end
      end
      CONV: begin
        {bcd_d, shift_d} = {bcd_adj[BW-2:0], shift_q, 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = LATCH;
      end
      LATCH: begin
        disp_d  = build;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Refresh scan: the digit selected by idx_q is loaded on the wrap, then idx advances.
  always_comb begin
    div_d   = div_q + DW'(1);
    idx_d   = idx_q;
    enbar_d = enbar_q;
    seg_d   = seg_q;
    if (div_q == DW'(SCAN_DIV-1)) begin
      div_d   = '0;
      enbar_d = ~(DIGITS'(1) << idx_q);
      seg_d   = disp_q[idx_q];
      idx_d   = (idx_q == IW'(DIGITS-1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      snap_vld_q  <= 1'b0;
      snap_in_q   <= '0;
      snap_mode_q <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      shift_q     <= '0;
      disp_q      <= {DIGITS{SEG_BLANK}};
      div_q       <= '0;
      idx_q       <= '0;
      enbar_q     <= '1;
      seg_q       <= SEG_BLANK;
    end else begin
      state_q     <= state_d;
      snap_vld_q  <= snap_vld_d;
      snap_in_q   <= snap_in_d;
      snap_mode_q <= snap_mode_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      shift_q     <= shift_d;
      disp_q      <= disp_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      enbar_q     <= enbar_d;
      seg_q       <= seg_d;
    end
  end

  assign ENBAR = enbar_q;
  assign SEG   = seg_q;
  assign BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_seg_display_mux.sv
// Randomised and directed bench for seg_display_mux against an arithmetic display model.
module tb_seg_display_mux;
  localparam int WIDTH    = 16;
  localparam int DIGITS   = 6;
  localparam int SCAN_DIV = 4;

  localparam logic [6:0] SEGTAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_v = '0;
  logic [1:0]  mode = '0;
  logic        blank = 1'b0;
  logic [5:0]  enbar;
  logic [6:0]  seg;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Model state: what the display should currently hold.
  logic        m_vld = 1'b0;
  logic [15:0] m_in = '0;
  logic [1:0]  m_mode = '0;
  logic        m_blank = 1'b0;

  seg_display_mux #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .CLK(clk), .RST(rst), .IN(in_v), .MODE(mode), .BLANK(blank),
    .ENBAR(enbar), .SEG(seg), .BUSY(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0][6:0] model(input logic [15:0] v, input logic [1:0] m, input logic b);
    int dig [6];
    int nd, top, mag;
    logic neg;
    logic [5:0][6:0] r;
    neg = (m == 2'd2) && v[15];
    if (m == 2'd0) begin
      nd = 4;
      for (int i = 0; i < 6; i++) dig[i] = (i < 4) ? int'((v >> (4*i)) & 16'hF) : 0;
    end else begin
      nd  = 5;
      mag = neg ? 65536 - int'(v) : int'(v);
      for (int i = 0; i < 6; i++) begin
        dig[i] = mag % 10;
        mag    = mag / 10;
      end
    end
    top = 0;
    for (int i = 0; i < nd; i++) if (dig[i] != 0) top = i;
    for (int i = 0; i < 6; i++) r[i] = (i >= nd || (b && i > top)) ? 7'h7F : SEGTAB[dig[i]];
    if (m == 2'd2) r[5] = neg ? 7'h3F : 7'h7F;
    return r;
  endfunction

  task automatic run_busy(output int n);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Let the scan refresh every digit, then record one full scan.
  task automatic grab(output logic [5:0][6:0] got, output int werr);
    int prev, k;
    logic [5:0] mask;
    got  = 'x;
    werr = 0;
    prev = -1;
    repeat (SCAN_DIV*DIGITS + 2) @(negedge clk);
    for (int c = 0; c < SCAN_DIV*DIGITS; c++) begin
      @(negedge clk);
      k = -1;
      for (int j = 0; j < DIGITS; j++) begin
        mask = ~(6'd1 << j);
        if (enbar === mask) k = j;
      end
      if (k < 0) werr++;
      else begin
        if (prev >= 0 && k != prev && k != (prev + 1) % DIGITS) werr++;
        prev   = k;
        got[k] = seg;
      end
    end
  endtask

  task automatic check_disp(input string tag, output logic [5:0][6:0] got);
    logic [5:0][6:0] exp;
    int werr;
    grab(got, werr);
    chk({tag, "/walk"}, 64'(werr), 64'd0);
    exp = model(m_in, m_mode, m_blank);
    for (int k = 0; k < DIGITS; k++)
      chk($sformatf("%s/d%0d", tag, k), 64'(got[k]), 64'(exp[k]));
  endtask

  task automatic apply(input string tag, input logic [15:0] v, input logic [1:0] m, input logic b,
                       output logic [5:0][6:0] got);
    logic changed;
    int n, exp_n;
    changed = !m_vld || v != m_in || m != m_mode;
    in_v  = v;
    mode  = m;
    blank = b;
    exp_n = 0;
    if (changed) begin
      m_vld   = 1'b1;
      m_in    = v;
      m_mode  = m;
      m_blank = b;
      exp_n   = (m == 2'd0) ? 1 : WIDTH + 1;
    end
    run_busy(n);
    chk({tag, "/busy"}, 64'(n), 64'(exp_n));
    check_disp(tag, got);
  endtask

  initial begin
    logic [5:0][6:0] got;
    logic [63:0] pat, exp_pat;
    logic [15:0] v;
    logic [1:0] m;
    int n;

    in_v = 16'd1234; mode = 2'd1; blank = 1'b1; rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_enbar", 64'(enbar), 64'h3F);
    chk("rst_seg",   64'(seg),   64'h7F);
    chk("rst_busy",  64'(busy),  64'd0);

    rst = 1'b0;
    m_vld = 1'b1; m_in = 16'd1234; m_mode = 2'd1; m_blank = 1'b1;
    n = 0;
    while (enbar === 6'h3F && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("first_wrap", 64'(n), 64'(SCAN_DIV));
    chk("first_en",   64'(enbar), 64'h3E);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("dec1234_done", 64'(busy), 64'd0);
    check_disp("dec1234", got);
    chk("dec1234_lit", 64'(got), 64'({7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}));

    apply("hexFAAA", 16'hFAAA, 2'd0, 1'b0, got);
    chk("hexFAAA_lit", 64'(got), 64'({7'h7F, 7'h7F, 7'h0E, 7'h08, 7'h08, 7'h08}));
    apply("s8000", 16'h8000, 2'd2, 1'b0, got);
    chk("s8000_lit", 64'(got), 64'({7'h3F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h00}));
    apply("sFFFF", 16'hFFFF, 2'd2, 1'b1, got);
    chk("sFFFF_lit", 64'(got), 64'({7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79}));
    apply("zero_b1", 16'd0, 2'd1, 1'b1, got);
    chk("zero_b1_lit", 64'(got), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
    apply("zero_blank_only", 16'd0, 2'd1, 1'b0, got);
    apply("zero_m3_b0", 16'd0, 2'd3, 1'b0, got);
    chk("zero_b0_lit", 64'(got), 64'({7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}));

    // IN change during CONV: the running conversion finishes, then the new value converts.
    in_v = 16'd4321; mode = 2'd1; blank = 1'b0;
    pat = '0;
    exp_pat = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      pat[k] = busy;
      exp_pat[k] = (k <= WIDTH + 1) || (k >= WIDTH + 3 && k <= 2*WIDTH + 3);
      if (k == 5) in_v = 16'd9876;
    end
    chk("midconv_busy", pat, exp_pat);
    m_in = 16'd9876; m_mode = 2'd1; m_blank = 1'b0;
    check_disp("midconv", got);

    // Reset during CONV: outputs clear at once, conversion restarts after release.
    in_v = 16'd5555; mode = 2'd1; blank = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_enbar", 64'(enbar), 64'h3F);
    chk("arst_seg",   64'(seg),   64'h7F);
    chk("arst_busy",  64'(busy),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_in = 16'd5555; m_mode = 2'd1; m_blank = 1'b1;
    run_busy(n);
    chk("arst_restart_busy", 64'(n), 64'(WIDTH + 1));
    check_disp("arst", got);

    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 7))
        0: v = 16'h0000;
        1: v = 16'h8000;
        2: v = 16'hFFFF;
        3: v = 16'h7FFF;
        4: v = 16'd10000;
        default: v = 16'($urandom);
      endcase
      m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) begin
        v = m_in;
        m = m_mode;
      end
      apply($sformatf("rnd%0d", it), v, m, 1'($urandom_range(0, 1)), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
